// File: rtl/cache_wb_pkg.sv
// Shared types for the posted cache write buffer.
//   wb_state_t : drain FSM states (IDLE, REQ)
//   wb_entry_t : one buffered write {valid, addr, data} at the default widths
//   PTR_W      : head/tail pointer width for the default depth
package cache_wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 8;
  localparam int WB_DEPTH  = 4;
  localparam int PTR_W     = $clog2(WB_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_addr_match.sv
// DEPTH-way address comparator for the write buffer.
//   i_valid  : per-entry qualifier (entries excluded from the search are 0)
//   i_addr   : per-entry stored addresses
//   i_key    : address being searched for
//   i_head   : oldest entry; age increases away from it toward the tail
//   o_match  : one-hot-or-more vector of qualified matches
//   o_idx    : index of the youngest match (0 when there is none)
module wb_addr_match #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0]            i_key,
  input  logic [PW-1:0]                i_head,
  output logic [DEPTH-1:0]             o_match,
  output logic [PW-1:0]                o_idx
);

  logic [PW-1:0] w_pos;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign o_match[gi] = i_valid[gi] && (i_addr[gi] == i_key);
  end

  // Walk from the head outward; the last hit seen is the one nearest the tail.
  always_comb begin
    o_idx = '0;
    w_pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_pos = i_head + PW'(k);
      if (o_match[w_pos]) o_idx = w_pos;
    end
  end

endmodule

// File: rtl/cache_write_buffer.sv
// Posted write buffer between the cache controller and main memory.
// Writes are queued in a circular FIFO and drained over a req/ack handshake;
// repeated writes to a queued (not in-flight) address are merged, and reads
// are forwarded from the youngest buffered copy.
//   clk, rst_n              : clock, asynchronous active-low reset
//   i_wr_valid/addr/data    : write from the controller
//   o_full, o_empty         : occupancy flags (registered)
//   o_mem_req/addr/data     : write request to memory, i_mem_ack accepts it
//   i_lk_addr               : read lookup address
//   o_lk_hit, o_lk_data     : forwarding result (combinational)
module cache_write_buffer
  import cache_wb_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic              i_mem_ack,
  input  logic [ADDR_W-1:0] i_lk_addr,
  output logic              o_lk_hit,
  output logic [DATA_W-1:0] o_lk_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_state_t                   r_state, w_state_next;
  logic [PW-1:0]               r_head, r_tail;
  logic [CW-1:0]               r_count, w_count_next;
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;

  logic             w_full, w_empty, w_inflight;
  logic [DEPTH-1:0] w_head_onehot, w_wr_mask;
  logic [DEPTH-1:0] w_lk_match, w_co_match;
  logic [PW-1:0]    w_lk_idx, w_co_idx;
  logic             w_co_hit, w_coalesce, w_push, w_pop;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_inflight = (r_state == REQ);
  assign o_full     = w_full;
  assign o_empty    = w_empty;

  // The head being presented to memory must not change under the handshake,
  // so it is hidden from the merge search while a request is outstanding.
  assign w_head_onehot = {{(DEPTH-1){1'b0}}, 1'b1} << r_head;
  assign w_wr_mask     = r_valid & ~(w_inflight ? w_head_onehot : '0);

  wb_addr_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_lk_match (
    .i_valid (r_valid),
    .i_addr  (r_addr),
    .i_key   (i_lk_addr),
    .i_head  (r_head),
    .o_match (w_lk_match),
    .o_idx   (w_lk_idx)
  );

  wb_addr_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_wr_match (
    .i_valid (w_wr_mask),
    .i_addr  (r_addr),
    .i_key   (i_wr_addr),
    .i_head  (r_head),
    .o_match (w_co_match),
    .o_idx   (w_co_idx)
  );

  assign o_lk_hit  = |w_lk_match;
  assign o_lk_data = o_lk_hit ? r_data[w_lk_idx] : '0;

  // A merge needs no free slot, so it is taken even when full.
  assign w_co_hit   = |w_co_match;
  assign w_coalesce = i_wr_valid && w_co_hit;
  assign w_push     = i_wr_valid && !w_co_hit && !w_full;
  assign w_pop      = w_inflight && i_mem_ack;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_next = r_count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_count <= w_count_next;
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= i_wr_addr;
        r_data[r_tail]  <= i_wr_data;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_coalesce) r_data[w_co_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_mem_req    = 1'b0;
    o_mem_addr   = '0;
    o_mem_data   = '0;
    case (r_state)
      IDLE: if (!w_empty) w_state_next = REQ;
      REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_addr[r_head];
        o_mem_data = r_data[r_head];
        // Stay in REQ while anything remains so the next entry goes out back-to-back.
        if (i_mem_ack && (w_count_next == '0)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_write_buffer.sv
module tb_cache_write_buffer;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          full, empty, mem_req, mem_ack, lk_hit;
  logic [AW-1:0] mem_addr, lk_addr;
  logic [DW-1:0] mem_data, lk_data;

  cache_write_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_valid (wr_valid),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_full     (full),
    .o_empty    (empty),
    .o_mem_req  (mem_req),
    .o_mem_addr (mem_addr),
    .o_mem_data (mem_data),
    .i_mem_ack  (mem_ack),
    .i_lk_addr  (lk_addr),
    .o_lk_hit   (lk_hit),
    .o_lk_data  (lk_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
  endtask

  // Bounded wait for a pending memory request.
  task automatic wait_req(input string name);
    int n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    chk({name, "_req_timeout"}, mem_req, 1'b1);
  endtask

  logic [AW-1:0] exp_a[$];
  logic [DW-1:0] exp_d[$];

  // Acknowledge every request and compare against the expected memory writes in order.
  task automatic drain(input string name);
    mem_ack = 1'b1;
    while (exp_a.size() > 0) begin
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      ea = exp_a.pop_front();
      ed = exp_d.pop_front();
      wait_req(name);
      $display("%s: memory write addr=%08h data=%02h", name, mem_addr, mem_data);
      chk({name, "_mem_addr"}, mem_addr, ea);
      chk({name, "_mem_data"}, {24'h0, mem_data}, {24'h0, ed});
      step();
    end
    mem_ack = 1'b0;
    chk({name, "_empty_after"}, empty, 1'b1);
    chk({name, "_req_after"}, mem_req, 1'b0);
  endtask

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ack;
    logic [AW-1:0] la;
    logic          req;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          fl;
    logic          em;
    logic          hit;
    logic [DW-1:0] ld;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic ack, input logic [AW-1:0] la, input logic req,
                              input logic [AW-1:0] ma, input logic [DW-1:0] md, input logic fl,
                              input logic em, input logic hit, input logic [DW-1:0] ld);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.ack = ack; v.la = la;
    v.req = req; v.ma = ma; v.md = md; v.fl = fl; v.em = em; v.hit = hit; v.ld = ld;
    return v;
  endfunction

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];
  bit   m_req;

  initial begin
    rst_n = 1'b0;
    set_wr(1'b0, '0, '0);
    mem_ack = 1'b0;
    lk_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req", mem_req, 1'b0);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_data", {24'h0, mem_data}, 32'h0);
    chk("reset_full", full, 1'b0);
    chk("reset_empty", empty, 1'b1);
    chk("reset_hit", lk_hit, 1'b0);
    rst_n = 1'b1;
    step();

    // Cycle-by-cycle vectors: single write latency, then fill / drop / back-to-back drain.
    vq.push_back(mk(1, 32'h10, 8'hA5, 0, 32'h10, 0, 32'h0,  8'h00, 0, 1, 0, 8'h00));
    vq.push_back(mk(0, 32'h0,  8'h00, 0, 32'h10, 0, 32'h0,  8'h00, 0, 0, 1, 8'hA5));
    vq.push_back(mk(0, 32'h0,  8'h00, 0, 32'h10, 1, 32'h10, 8'hA5, 0, 0, 1, 8'hA5));
    vq.push_back(mk(0, 32'h0,  8'h00, 1, 32'h10, 1, 32'h10, 8'hA5, 0, 0, 1, 8'hA5));
    vq.push_back(mk(0, 32'h0,  8'h00, 0, 32'h10, 0, 32'h0,  8'h00, 0, 1, 0, 8'h00));
    vq.push_back(mk(1, 32'h10, 8'h50, 0, 32'h13, 0, 32'h0,  8'h00, 0, 1, 0, 8'h00));
    vq.push_back(mk(1, 32'h11, 8'h51, 0, 32'h10, 0, 32'h0,  8'h00, 0, 0, 1, 8'h50));
    vq.push_back(mk(1, 32'h12, 8'h52, 0, 32'h11, 1, 32'h10, 8'h50, 0, 0, 1, 8'h51));
    vq.push_back(mk(1, 32'h13, 8'h53, 0, 32'h12, 1, 32'h10, 8'h50, 0, 0, 1, 8'h52));
    vq.push_back(mk(1, 32'h20, 8'hEE, 0, 32'h13, 1, 32'h10, 8'h50, 1, 0, 1, 8'h53));
    vq.push_back(mk(0, 32'h0,  8'h00, 1, 32'h20, 1, 32'h10, 8'h50, 1, 0, 0, 8'h00));
    vq.push_back(mk(0, 32'h0,  8'h00, 1, 32'h10, 1, 32'h11, 8'h51, 0, 0, 0, 8'h00));
    vq.push_back(mk(0, 32'h0,  8'h00, 1, 32'h13, 1, 32'h12, 8'h52, 0, 0, 1, 8'h53));
    vq.push_back(mk(0, 32'h0,  8'h00, 1, 32'h13, 1, 32'h13, 8'h53, 0, 0, 1, 8'h53));
    vq.push_back(mk(0, 32'h0,  8'h00, 0, 32'h13, 0, 32'h0,  8'h00, 0, 1, 0, 8'h00));

    for (int i = 0; i < vq.size(); i++) begin
      set_wr(vq[i].wv, vq[i].wa, vq[i].wd);
      mem_ack = vq[i].ack;
      lk_addr = vq[i].la;
      @(negedge clk);
      $display("vec %0d: req=%0b addr=%08h data=%02h full=%0b empty=%0b hit=%0b lk=%02h",
               i, mem_req, mem_addr, mem_data, full, empty, lk_hit, lk_data);
      chk($sformatf("vec%0d_req", i), mem_req, vq[i].req);
      chk($sformatf("vec%0d_addr", i), mem_addr, vq[i].ma);
      chk($sformatf("vec%0d_data", i), {24'h0, mem_data}, {24'h0, vq[i].md});
      chk($sformatf("vec%0d_full", i), full, vq[i].fl);
      chk($sformatf("vec%0d_empty", i), empty, vq[i].em);
      chk($sformatf("vec%0d_hit", i), lk_hit, vq[i].hit);
      chk($sformatf("vec%0d_lkdata", i), {24'h0, lk_data}, {24'h0, vq[i].ld});
      step();
    end
    set_wr(1'b0, '0, '0);
    mem_ack = 1'b0;
    step();

    // Merge into a queued entry while the head is in flight.
    set_wr(1'b1, 32'h40, 8'h11); step();
    set_wr(1'b1, 32'h44, 8'h22); step();
    set_wr(1'b0, '0, '0);
    wait_req("coal");
    chk("coal_inflight_addr", mem_addr, 32'h40);
    set_wr(1'b1, 32'h44, 8'h33); step();
    set_wr(1'b0, '0, '0);
    lk_addr = 32'h44; #1;
    chk("coal_lk_data", {24'h0, lk_data}, 32'h33);
    exp_a = '{32'h40, 32'h44};
    exp_d = '{8'h11, 8'h33};
    drain("coal");

    // A write matching the in-flight head allocates; lookup returns the youngest copy.
    set_wr(1'b1, 32'h44, 8'h22); step();
    set_wr(1'b0, '0, '0);
    wait_req("fwd");
    chk("fwd_inflight_addr", mem_addr, 32'h44);
    set_wr(1'b1, 32'h44, 8'h99); step();
    set_wr(1'b0, '0, '0);
    lk_addr = 32'h44; #1;
    chk("fwd_hit44", lk_hit, 1'b1);
    chk("fwd_data44", {24'h0, lk_data}, 32'h99);
    lk_addr = 32'h48; #1;
    chk("fwd_hit48", lk_hit, 1'b0);
    chk("fwd_data48", {24'h0, lk_data}, 32'h0);
    exp_a = '{32'h44, 32'h44};
    exp_d = '{8'h22, 8'h99};
    drain("fwd");

    // Full buffer: write and ack in the same cycle -> pop happens, write dropped.
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, 32'h60 + 32'(i), 8'h60 + 8'(i));
      step();
    end
    set_wr(1'b0, '0, '0);
    wait_req("fullack");
    chk("fullack_full", full, 1'b1);
    set_wr(1'b1, 32'h70, 8'h77);
    mem_ack = 1'b1;
    step();
    set_wr(1'b0, '0, '0);
    mem_ack = 1'b0;
    chk("fullack_full_after", full, 1'b0);
    lk_addr = 32'h70; #1;
    chk("fullack_dropped", lk_hit, 1'b0);
    exp_a = '{32'h61, 32'h62, 32'h63};
    exp_d = '{8'h61, 8'h62, 8'h63};
    drain("fullack");

    // Asynchronous reset mid-handshake.
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, 32'h80 + 32'(i), 8'h80 + 8'(i));
      step();
    end
    set_wr(1'b0, '0, '0);
    wait_req("rst");
    lk_addr = 32'h80;
    #1;
    chk("rst_pre_full", full, 1'b1);
    chk("rst_pre_hit", lk_hit, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_req", mem_req, 1'b0);
    chk("rst_async_addr", mem_addr, 32'h0);
    chk("rst_async_full", full, 1'b0);
    chk("rst_async_empty", empty, 1'b1);
    chk("rst_async_hit", lk_hit, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Randomized traffic against a queue model.
    mq.delete();
    m_req = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      logic          e_req, e_hit;
      logic [AW-1:0] e_ma;
      logic [DW-1:0] e_md, e_ld;
      int            j;
      bit            was_ne, was_full;
      set_wr(($urandom_range(0, 99) < 45), 32'h100 + 32'(4 * $urandom_range(0, 5)), 8'($urandom));
      mem_ack = ($urandom_range(0, 2) != 0);
      lk_addr = 32'h100 + 32'(4 * $urandom_range(0, 6));
      e_req = m_req;
      e_ma  = (m_req && mq.size() > 0) ? mq[0].a : '0;
      e_md  = (m_req && mq.size() > 0) ? mq[0].d : '0;
      e_hit = 1'b0;
      e_ld  = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!e_hit && mq[i].a == lk_addr) begin
          e_hit = 1'b1;
          e_ld  = mq[i].d;
        end
      end
      @(negedge clk);
      chk($sformatf("rnd%0d_req", cyc), mem_req, e_req);
      chk($sformatf("rnd%0d_addr", cyc), mem_addr, e_ma);
      chk($sformatf("rnd%0d_data", cyc), {24'h0, mem_data}, {24'h0, e_md});
      chk($sformatf("rnd%0d_full", cyc), full, (mq.size() == DEPTH));
      chk($sformatf("rnd%0d_empty", cyc), empty, (mq.size() == 0));
      chk($sformatf("rnd%0d_hit", cyc), lk_hit, e_hit);
      chk($sformatf("rnd%0d_lkdata", cyc), {24'h0, lk_data}, {24'h0, e_ld});
      was_ne   = (mq.size() > 0);
      was_full = (mq.size() == DEPTH);
      j = -1;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (j < 0 && mq[i].a == wr_addr && !(m_req && i == 0)) j = i;
      end
      if (wr_valid) begin
        if (j >= 0) mq[j].d = wr_data;
        else if (!was_full) mq.push_back('{wr_addr, wr_data});
      end
      if (m_req) begin
        if (mem_ack) begin
          void'(mq.pop_front());
          m_req = (mq.size() > 0);
        end
      end else begin
        m_req = was_ne;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
